// File: rtl/arb_pkg.sv
// Shared encodings for the two-master data-bus arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner selection between the two masters.
// ARB_FIXED_PRIO_EN: master 0 always wins ties (default build is round-robin).
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_idx
);

    always_comb begin
        grant_valid = req0 | req1;
`ifdef ARB_FIXED_PRIO_EN
        // last_grant only fills the don't-care slot when nobody requests
        grant_idx = req0 ? M0 : (req1 ? M1 : last_grant);
`else
        if (req0 && req1) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = req0 ? M0 : M1;
        end
`endif
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master, one-slave data-bus arbiter with programmable wait states.
// Build option ARB_FIXED_PRIO_EN selects fixed master-0 priority (see arb_rr_pick).
module bus_arbiter #(
    parameter int WAIT_CYCLES = 0,
    parameter int DATA_W      = 32
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_stall,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_stall,
    output logic [DATA_W-1:0] Bus_addr,
    output logic              Bus_we,
    output logic [DATA_W-1:0] Bus_wdata,
    input  logic [DATA_W-1:0] Bus_rdata,
    output logic              busy
);
    import arb_pkg::*;

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > (1 << WAIT_CNT_W) - 1) begin : g_bad_wait
        $error("bus_arbiter: WAIT_CYCLES must be in 0..15");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt;
    logic                  r_grant;
    logic                  r_last_grant;
    logic                  r_we;
    logic [DATA_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W-1:0]     r_m0_rdata;
    logic [DATA_W-1:0]     r_m1_rdata;
    logic                  w_grant_valid;
    logic                  w_grant_idx;
    logic                  w_access;
    logic                  w_resp;
    logic                  w_cnt_zero;

    arb_rr_pick u_pick (
        .req0        (m0_req),
        .req1        (m1_req),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_valid) w_state_nxt = ACCESS;
            ACCESS:  if (w_cnt_zero) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_cnt        <= '0;
            r_grant      <= M0;
            r_last_grant <= M1;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_grant <= w_grant_idx;
                        r_cnt   <= WAIT_CNT_W'(WAIT_CYCLES);
                        if (w_grant_idx == M1) begin
                            r_we    <= m1_we;
                            r_addr  <= m1_addr;
                            r_wdata <= m1_wdata;
                        end else begin
                            r_we    <= m0_we;
                            r_addr  <= m0_addr;
                            r_wdata <= m0_wdata;
                        end
                    end
                end
                ACCESS: begin
                    if (!w_cnt_zero) begin
                        r_cnt <= r_cnt - WAIT_CNT_W'(1);
                    end else if (r_grant == M1) begin
                        r_m1_rdata <= Bus_rdata;
                    end else begin
                        r_m0_rdata <= Bus_rdata;
                    end
                end
                RESP:    r_last_grant <= r_grant;
                default: ;
            endcase
        end
    end

    assign w_access   = (r_state == ACCESS);
    assign w_resp     = (r_state == RESP);
    assign w_cnt_zero = (r_cnt == '0);

    // Write strobe only in the final ACCESS cycle, so a reset during wait states never writes
    assign Bus_addr  = w_access ? r_addr  : '0;
    assign Bus_wdata = w_access ? r_wdata : '0;
    assign Bus_we    = w_access & r_we & w_cnt_zero;

    assign m0_ack   = w_resp & (r_grant == M0);
    assign m1_ack   = w_resp & (r_grant == M1);
    assign m0_stall = m0_req & ~m0_ack;
    assign m1_stall = m1_req & ~m1_ack;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;
    assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised scoreboard bench for bus_arbiter: a transaction-level model predicts
// bus activity, acks and read data; a separate monitor compares every cycle.
`timescale 1ns/1ps
module tb_bus_arbiter;

    localparam int W = 2;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [31:0] m0_rdata, m1_rdata, Bus_addr, Bus_wdata, Bus_rdata;
    logic        m0_ack, m0_stall, m1_ack, m1_stall, Bus_we, busy;

    bus_arbiter #(.WAIT_CYCLES(W), .DATA_W(32)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_stall(m1_stall),
        .Bus_addr(Bus_addr), .Bus_we(Bus_we), .Bus_wdata(Bus_wdata),
        .Bus_rdata(Bus_rdata), .busy(busy)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Slave returns a fixed scramble of the address
    function automatic logic [31:0] bus_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction
    assign Bus_rdata = bus_fn(Bus_addr);

    int cyc = 0;
    always @(posedge cpu_clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    typedef struct {
        int          start;
        bit          idx;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          free_at  = 0;
    bit          last_win = 1'b1;
    logic [31:0] exp_rd[2] = '{32'h0, 32'h0};

    bit          act[2]      = '{0, 0};
    bit          t_we[2]     = '{0, 0};
    logic [31:0] t_addr[2]   = '{32'h0, 32'h0};
    logic [31:0] t_wdata[2]  = '{32'h0, 32'h0};
    bit          seen_ack[2] = '{0, 0};

    // One cycle of stimulus; the model records the transaction the moment the bus accepts it
    task automatic step(input int unsigned prob, input bit rst_now);
        int c;
        bit w;
        @(negedge cpu_clk);
        seen_ack[0] = m0_ack;
        seen_ack[1] = m1_ack;
        @(posedge cpu_clk);
        #1;
        c = cyc;
        for (int m = 0; m < 2; m++) begin
            if (act[m] && seen_ack[m]) act[m] = 1'b0;
            if (!act[m] && prob != 0 && $urandom_range(99) < prob) begin
                act[m]     = 1'b1;
                t_we[m]    = $urandom_range(1) == 1;
                t_addr[m]  = $urandom & 32'hFFFF_FFFC;
                t_wdata[m] = $urandom;
            end
            if (rst_now) act[m] = 1'b0;
        end
        cpu_rst  = rst_now;
        m0_req   = act[0]; m0_we = t_we[0]; m0_addr = t_addr[0]; m0_wdata = t_wdata[0];
        m1_req   = act[1]; m1_we = t_we[1]; m1_addr = t_addr[1]; m1_wdata = t_wdata[1];
        if (rst_now) begin
            free_at  = c + 1;
            last_win = 1'b1;
        end else if (c >= free_at && (act[0] || act[1])) begin
            if (act[0] && act[1]) begin
`ifdef ARB_FIXED_PRIO_EN
                w = 1'b0;
`else
                w = !last_win;
`endif
            end else begin
                w = act[1];
            end
            exp_q.push_back('{start: c, idx: w, we: t_we[w], addr: t_addr[w], wdata: t_wdata[w]});
            free_at  = c + 3 + W;
            last_win = w;
        end
    endtask

    task automatic run_txn(input int m, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
        act[m] = 1'b1; t_we[m] = we; t_addr[m] = addr; t_wdata[m] = wdata;
        for (int i = 0; i < 20 && act[m]; i++) step(0, 1'b0);
        check("txn_completed", {31'b0, act[m]}, 32'h0);
        act[m] = 1'b0;
    endtask

    // Monitor: derives every expected output of the current cycle from the scoreboard head
    initial begin
        exp_t        e;
        int          c;
        bit          e_busy, e_we, pop;
        bit          e_ack[2];
        logic [31:0] e_addr, e_wdata;
        forever begin
            @(negedge cpu_clk);
            c = cyc;
            e_busy = 0; e_we = 0; pop = 0; e_ack[0] = 0; e_ack[1] = 0;
            e_addr = '0; e_wdata = '0;
            if (exp_q.size() != 0) begin
                e = exp_q[0];
                if (c > e.start) e_busy = 1;
                if (c > e.start && c <= e.start + 1 + W) begin
                    e_addr  = e.addr;
                    e_wdata = e.wdata;
                    e_we    = e.we && (c == e.start + 1 + W);
                end
                if (c == e.start + 2 + W) begin
                    e_ack[e.idx]  = 1;
                    exp_rd[e.idx] = bus_fn(e.addr);
                    pop = 1;
                end
            end
            check("busy",      {31'b0, busy},     {31'b0, e_busy});
            check("Bus_addr",  Bus_addr,          e_addr);
            check("Bus_wdata", Bus_wdata,         e_wdata);
            check("Bus_we",    {31'b0, Bus_we},   {31'b0, e_we});
            check("m0_ack",    {31'b0, m0_ack},   {31'b0, e_ack[0]});
            check("m1_ack",    {31'b0, m1_ack},   {31'b0, e_ack[1]});
            check("m0_rdata",  m0_rdata,          exp_rd[0]);
            check("m1_rdata",  m1_rdata,          exp_rd[1]);
            check("m0_stall",  {31'b0, m0_stall}, {31'b0, m0_req & ~e_ack[0]});
            check("m1_stall",  {31'b0, m1_stall}, {31'b0, m1_req & ~e_ack[1]});
            if (pop) void'(exp_q.pop_front());
            if (cpu_rst) begin
                exp_q.delete();
                exp_rd[0] = '0;
                exp_rd[1] = '0;
            end
        end
    end

    initial begin
        int unsigned prob_tab[4] = '{30, 60, 90, 15};
        repeat (3) step(0, 1'b1);
        repeat (10) step(0, 1'b0);
        // contention from reset: both masters re-request immediately after each ack
        repeat (30) step(100, 1'b0);
        for (int i = 0; i < 40 && (act[0] || act[1]); i++) step(0, 1'b0);
        repeat (3 + W) step(0, 1'b0);
        run_txn(0, 1'b0, 32'h0000_1000, 32'h0);
        run_txn(1, 1'b1, 32'h8000_0004, 32'h1234_5678);
        run_txn(0, 1'b0, 32'h0000_0004, 32'h0);
        for (int ph = 0; ph < 4; ph++) begin
            repeat (400) step(prob_tab[ph], $urandom_range(299) == 0);
        end
        for (int i = 0; i < 40 && (act[0] || act[1]); i++) step(0, 1'b0);
        repeat (3 + W) step(0, 1'b0);
        // reset lands two cycles into a write's wait states
        act[0] = 1'b1; t_we[0] = 1'b1; t_addr[0] = 32'h0000_2000; t_wdata[0] = 32'hCAFE_F00D;
        step(0, 1'b0);
        step(0, 1'b0);
        step(0, 1'b1);
        step(0, 1'b0);
        run_txn(0, 1'b1, 32'h0000_2000, 32'hCAFE_F00D);
        run_txn(1, 1'b0, 32'h0000_3000, 32'h0);
        repeat (10) step(0, 1'b0);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
